// File: rtl/pool_scheduler_if.sv
// Handshake and memory-side bundle between the CU, feature memory, pool engine
// and output memory for the max-pool scheduler.
interface pool_scheduler_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  start;
  logic [7:0]            input_size;
  logic [7:0]            channel;
  logic [ADDR_WIDTH-1:0] in_base_addr;
  logic [ADDR_WIDTH-1:0] out_base_addr;
  logic                  hold;
  logic                  fm_rd_en;
  logic [ADDR_WIDTH-1:0] fm_rd_addr;
  logic                  pe_valid;
  logic                  pe_second_row;
  logic [6:0]            pe_buf_addr;
  logic                  out_wr_en;
  logic [ADDR_WIDTH-1:0] out_wr_addr;
  logic                  busy;
  logic                  done;

  modport master (
    output start, input_size, channel, in_base_addr, out_base_addr, hold,
    input  fm_rd_en, fm_rd_addr, pe_valid, pe_second_row, pe_buf_addr,
           out_wr_en, out_wr_addr, busy, done
  );

  modport slave (
    input  start, input_size, channel, in_base_addr, out_base_addr, hold,
    output fm_rd_en, fm_rd_addr, pe_valid, pe_second_row, pe_buf_addr,
           out_wr_en, out_wr_addr, busy, done
  );
endinterface

// File: rtl/pool_scheduler.sv
// 2x2 max-pool layer sequencer: walks row/colpair/channel-group, issues feature
// reads, tags returned words for the pool engine and generates output writes.
module pool_scheduler #(
  parameter int unsigned DATA_WIDTH       = 16,
  parameter int unsigned POOL_PARALLELISM = 8,
  parameter int unsigned ADDR_WIDTH       = 16,
  parameter int unsigned RD_LATENCY       = 2
) (
  input logic             clk,
  input logic             rst_n,
  pool_scheduler_if.slave bus
);

  localparam int unsigned SIZE_W  = 8;
  localparam int unsigned S2_W    = 7;
  localparam int unsigned G_W     = 9;
  localparam int unsigned BUF_W   = 7;
  localparam int unsigned DRAIN_W = $clog2(RD_LATENCY + 2);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  if (RD_LATENCY < 1 || DATA_WIDTH < 1 || POOL_PARALLELISM < 1) begin : g_param_check
    $error("pool_scheduler: RD_LATENCY, DATA_WIDTH and POOL_PARALLELISM must be >= 1");
  end

  logic [1:0]            state;
  logic [1:0]            next_state;
  logic                  rd_en_c;
  logic                  last_rd_c;
  logic                  start_ok_c;
  logic [S2_W-1:0]       s2_in_c;
  logic [G_W-1:0]        g_in_c;

  logic [S2_W-1:0]       s2_m1;
  logic [G_W-1:0]        g_m1;
  logic [SIZE_W-1:0]     row_m1;
  logic [ADDR_WIDTH-1:0] s2g;
  logic [G_W-1:0]        cgrp;
  logic [S2_W-1:0]       colpair;
  logic [SIZE_W-1:0]     row;
  logic [BUF_W-1:0]      buf_idx;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] out_row_base;
  logic [DRAIN_W-1:0]    drain_cnt;

  logic [RD_LATENCY-1:0] tag_valid;
  logic [RD_LATENCY-1:0] tag_second;
  logic [BUF_W-1:0]      tag_buf [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] tag_out [RD_LATENCY];

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  busy;
  logic                  done;

  // Layer geometry decoded from the CU inputs; C=0 still walks one group.
  always_comb begin
    s2_in_c = S2_W'(bus.input_size >> 1);
    g_in_c  = (G_W'(bus.channel) + G_W'(POOL_PARALLELISM - 1)) / G_W'(POOL_PARALLELISM);
    if (bus.channel == 8'd0) g_in_c = G_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_state
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin : p_next
    next_state = state;
    rd_en_c    = 1'b0;
    last_rd_c  = 1'b0;
    start_ok_c = 1'b0;
    case (state)
      ST_IDLE: begin
        start_ok_c = bus.start;
        if (bus.start) next_state = (s2_in_c == '0) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        rd_en_c   = !bus.hold;
        last_rd_c = rd_en_c && (cgrp == g_m1) && (colpair == s2_m1) && (row == row_m1);
        if (last_rd_c) next_state = ST_DRAIN;
      end
      ST_DRAIN: if (drain_cnt == DRAIN_W'(RD_LATENCY)) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Walk counters; buf_idx and the address registers track the nested loops incrementally.
  always_ff @(posedge clk or negedge rst_n) begin : p_walk
    if (!rst_n) begin
      s2_m1        <= '0;
      g_m1         <= '0;
      row_m1       <= '0;
      s2g          <= '0;
      cgrp         <= '0;
      colpair      <= '0;
      row          <= '0;
      buf_idx      <= '0;
      rd_addr      <= '0;
      out_row_base <= '0;
    end else if (start_ok_c) begin
      s2_m1        <= s2_in_c - S2_W'(1);
      g_m1         <= g_in_c - G_W'(1);
      row_m1       <= SIZE_W'({s2_in_c, 1'b0}) - SIZE_W'(1);
      s2g          <= ADDR_WIDTH'(s2_in_c) * ADDR_WIDTH'(g_in_c);
      cgrp         <= '0;
      colpair      <= '0;
      row          <= '0;
      buf_idx      <= '0;
      rd_addr      <= bus.in_base_addr;
      out_row_base <= bus.out_base_addr;
    end else if (rd_en_c) begin
      rd_addr <= rd_addr + ADDR_WIDTH'(1);
      if (cgrp == g_m1) begin
        cgrp <= '0;
        if (colpair == s2_m1) begin
          colpair <= '0;
          buf_idx <= '0;
          row     <= row + SIZE_W'(1);
          if (row[0]) out_row_base <= out_row_base + s2g;
        end else begin
          colpair <= colpair + S2_W'(1);
          buf_idx <= buf_idx + BUF_W'(1);
        end
      end else begin
        cgrp    <= cgrp + G_W'(1);
        buf_idx <= buf_idx + BUF_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_drain
    if (!rst_n)                 drain_cnt <= '0;
    else if (state != ST_DRAIN) drain_cnt <= '0;
    else                        drain_cnt <= drain_cnt + DRAIN_W'(1);
  end

  // Tags travel alongside the read and are never stalled by hold.
  always_ff @(posedge clk or negedge rst_n) begin : p_tags
    if (!rst_n) begin
      tag_valid  <= '0;
      tag_second <= '0;
      for (int i = 0; i < int'(RD_LATENCY); i++) begin
        tag_buf[i] <= '0;
        tag_out[i] <= '0;
      end
    end else begin
      tag_valid[0]  <= rd_en_c;
      tag_second[0] <= rd_en_c & row[0];
      tag_buf[0]    <= buf_idx;
      tag_out[0]    <= out_row_base + ADDR_WIDTH'(buf_idx);
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        tag_valid[i]  <= tag_valid[i-1];
        tag_second[i] <= tag_second[i-1];
        tag_buf[i]    <= tag_buf[i-1];
        tag_out[i]    <= tag_out[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_outs
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      wr_en <= tag_valid[RD_LATENCY-1] & tag_second[RD_LATENCY-1];
      if (tag_valid[RD_LATENCY-1] & tag_second[RD_LATENCY-1]) wr_addr <= tag_out[RD_LATENCY-1];
      busy  <= (next_state != ST_IDLE);
      done  <= (next_state == ST_DONE);
    end
  end

  assign bus.fm_rd_en      = rd_en_c;
  assign bus.fm_rd_addr    = rd_addr;
  assign bus.pe_valid      = tag_valid[RD_LATENCY-1];
  assign bus.pe_second_row = tag_second[RD_LATENCY-1];
  assign bus.pe_buf_addr   = tag_buf[RD_LATENCY-1];
  assign bus.out_wr_en     = wr_en;
  assign bus.out_wr_addr   = wr_addr;
  assign bus.busy          = busy;
  assign bus.done          = done;

endmodule

// File: tb/tb_pool_scheduler.sv
// Bench for pool_scheduler: directed layers plus random layers against a
// loop-nest reference model with per-cycle expected traffic.
module tb_pool_scheduler;
  localparam int unsigned AW  = 16;
  localparam int unsigned RDL = 2;
  localparam int unsigned P   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pool_scheduler_if #(.ADDR_WIDTH(AW)) bus ();

  pool_scheduler #(
    .DATA_WIDTH(16), .POOL_PARALLELISM(P), .ADDR_WIDTH(AW), .RD_LATENCY(RDL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    int due;
    int sec;
    int bufa;
    int waddr;
  } tag_t;

  int   checks = 0;
  int   failures = 0;
  int   exp_ra[$];
  tag_t exp_tag[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected read stream from the plain loop nest of the layer definition.
  task automatic build(input int s, input int c, input int inb, input int outb);
    int s2, g, idx;
    tag_t t;
    s2 = s / 2;
    g  = (c == 0) ? 1 : (c + P - 1) / P;
    exp_ra.delete();
    exp_tag.delete();
    for (int r = 0; r < 2 * s2; r++)
      for (int cp = 0; cp < s2; cp++)
        for (int cg = 0; cg < g; cg++) begin
          idx     = (r * s2 + cp) * g + cg;
          exp_ra.push_back((inb + idx) % 65536);
          t.due   = 0;
          t.sec   = r % 2;
          t.bufa  = cp * g + cg;
          t.waddr = (outb + ((r / 2) * s2 + cp) * g + cg) % 65536;
          exp_tag.push_back(t);
        end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_en"}, bus.fm_rd_en, 0);
    chk({tag, "_rd_addr"}, bus.fm_rd_addr, 0);
    chk({tag, "_pe_valid"}, bus.pe_valid, 0);
    chk({tag, "_pe_sec"}, bus.pe_second_row, 0);
    chk({tag, "_pe_buf"}, bus.pe_buf_addr, 0);
    chk({tag, "_wr_en"}, bus.out_wr_en, 0);
    chk({tag, "_wr_addr"}, bus.out_wr_addr, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
  endtask

  // hold_mode: 0 none, 1 random, 2 three cycles after the 2nd read.
  task automatic run_layer(input int s, input int c, input int inb, input int outb,
                           input int hold_mode, input int abort_after, input bit disturb,
                           output int done_at);
    int   n, issued, done_cyc, hold_cnt, cyc;
    bit   h, exp_en, exp_v, exp_w, finished;
    tag_t t, pend[$], wq[$];
    build(s, c, inb, outb);
    n        = exp_ra.size();
    issued   = 0;
    done_cyc = (n == 0) ? 1 : -1;
    hold_cnt = 0;
    done_at  = -1;
    finished = 1'b0;

    @(posedge clk); #1;
    bus.start         = 1'b1;
    bus.input_size    = 8'(s);
    bus.channel       = 8'(c);
    bus.in_base_addr  = 16'(inb);
    bus.out_base_addr = 16'(outb);
    bus.hold          = 1'b0;
    @(negedge clk);
    chk("c0_rd_en", bus.fm_rd_en, 0);
    chk("c0_busy", bus.busy, 0);

    for (cyc = 1; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (disturb && ((cyc == 3 && (done_cyc < 0 || cyc < done_cyc)) || cyc == done_cyc)) begin
        bus.start        = 1'b1;
        bus.input_size   = 8'($urandom_range(2, 12));
        bus.channel      = 8'($urandom);
        bus.in_base_addr = 16'($urandom);
      end
      case (hold_mode)
        1:       h = ($urandom_range(0, 3) == 0);
        2:       begin h = (hold_cnt > 0); if (hold_cnt > 0) hold_cnt--; end
        default: h = 1'b0;
      endcase
      bus.hold = h;

      @(negedge clk);
      exp_en = (issued < n) && !h;
      chk("fm_rd_en", bus.fm_rd_en, 32'(exp_en));
      if (exp_en) begin
        chk("fm_rd_addr", bus.fm_rd_addr, exp_ra[issued]);
        t     = exp_tag[issued];
        t.due = cyc + RDL;
        pend.push_back(t);
        issued++;
        if (issued == n) done_cyc = cyc + RDL + 2;
        if (hold_mode == 2 && issued == 2) hold_cnt = 3;
      end

      exp_v = (pend.size() > 0) && (pend[0].due == cyc);
      chk("pe_valid", bus.pe_valid, 32'(exp_v));
      if (exp_v) begin
        t = pend.pop_front();
        chk("pe_second_row", bus.pe_second_row, t.sec);
        chk("pe_buf_addr", bus.pe_buf_addr, t.bufa);
        if (t.sec != 0) begin
          t.due = cyc + 1;
          wq.push_back(t);
        end
      end

      exp_w = (wq.size() > 0) && (wq[0].due == cyc);
      chk("out_wr_en", bus.out_wr_en, 32'(exp_w));
      if (exp_w) begin
        t = wq.pop_front();
        chk("out_wr_addr", bus.out_wr_addr, t.waddr);
      end

      chk("busy", bus.busy, 32'(done_cyc < 0 || cyc <= done_cyc));
      chk("done", bus.done, 32'(cyc == done_cyc));
      if (bus.done === 1'b1 && done_at < 0) done_at = cyc;

      if (abort_after >= 0 && issued == abort_after) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        return;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        finished = 1'b1;
        break;
      end
    end

    if (!finished) begin
      checks++;
      failures++;
      $error("FAIL layer_timeout obs=issued %0d exp=reads %0d", issued, n);
    end
    chk("done_at", 32'(done_at), 32'(done_cyc));
    bus.start = 1'b0;
    bus.hold  = 1'b0;
  endtask

  initial begin : main
    int d, s, c;
    bus.start         = 1'b0;
    bus.hold          = 1'b0;
    bus.input_size    = 8'd0;
    bus.channel       = 8'd0;
    bus.in_base_addr  = 16'd0;
    bus.out_base_addr = 16'd0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    run_layer(4, 8, 'h100, 'h200, 0, -1, 1'b0, d);
    chk("t1_done_cycle", 32'(d), 12);
    run_layer(4, 16, 'h100, 'h200, 0, -1, 1'b0, d);
    chk("t2_done_cycle", 32'(d), 20);
    run_layer(4, 8, 'h100, 'h200, 2, -1, 1'b0, d);
    chk("t3_done_cycle", 32'(d), 15);
    run_layer(1, 8, 'h100, 'h200, 1, -1, 1'b0, d);
    chk("t4_s1_done_cycle", 32'(d), 1);
    run_layer(0, 8, 'h100, 'h200, 0, -1, 1'b0, d);
    chk("t4_s0_done_cycle", 32'(d), 1);
    run_layer(6, 8, 'h100, 'h200, 0, 5, 1'b0, d);
    run_layer(6, 8, 'h100, 'h200, 0, -1, 1'b0, d);
    chk("t5_rerun_done_cycle", 32'(d), 22);
    run_layer(4, 8, 'h100, 'h200, 0, -1, 1'b1, d);
    chk("t6_done_cycle", 32'(d), 12);
    run_layer(5, 0, 'hFFFC, 'hFFFE, 0, -1, 1'b0, d);
    chk("wrap_done_cycle", 32'(d), 12);

    for (int i = 0; i < 12; i++) begin
      s = $urandom_range(0, 10);
      c = $urandom_range(0, 40);
      run_layer(s, c, $urandom_range(0, 65535), $urandom_range(0, 65535), 1, -1,
                1'($urandom_range(0, 1)), d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
